// File: rtl/key_detector.sv
// key_detector: counts dark pixels per key column inside a horizontal band of each
// camera frame, then applies hysteresis and debounce and publishes per-key press state.
module key_detector #(
  parameter int          IMG_W    = 320,
  parameter int          IMG_H    = 240,
  parameter int          KEYS     = 8,
  parameter int          ROW_TOP  = 160,
  parameter int          ROW_BOT  = 239,
  parameter logic [7:0]  LUMA_TH  = 8'd60,
  parameter logic [11:0] ON_TH    = 12'd1200,
  parameter logic [11:0] OFF_TH   = 12'd800,
  parameter int          DEBOUNCE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pix_valid,
  input  logic            pix_sof,
  input  logic [15:0]     pix_data,
  output logic [KEYS-1:0] key_state,
  output logic [KEYS-1:0] key_on,
  output logic [KEYS-1:0] key_off,
  output logic            frame_done,
  output logic [15:0]     debug_out
);

  localparam int KEY_W = IMG_W / KEYS;
  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);
  localparam int KW    = (KEYS > 1) ? $clog2(KEYS) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_TOP  = YW'(ROW_TOP);
  localparam logic [YW-1:0] Y_BOT  = YW'(ROW_BOT);
  localparam logic [XW-1:0] X_KEYW = XW'(KEY_W);
  localparam logic [KW-1:0] K_LAST = KW'(KEYS - 1);
  localparam logic [1:0]    DEB    = 2'(DEBOUNCE);

  typedef enum logic [2:0] {
    WAIT_SOF = 3'd0,
    ACCUM    = 3'd1,
    FLUSH    = 3'd2,
    EVAL     = 3'd3,
    PUBLISH  = 3'd4
  } state_t;

  // Weighted luma of an RGB565 pixel: each channel widened to 8 bits, then r/4 + g/2 + b/4.
  function automatic logic [7:0] luma_f(input logic [15:0] p);
    logic [7:0] r8;
    logic [7:0] g8;
    logic [7:0] b8;
    r8 = {p[15:11], 3'b000};
    g8 = {p[10:5], 2'b00};
    b8 = {p[4:0], 3'b000};
    return (r8 >> 3'd2) + (g8 >> 3'd1) + (b8 >> 3'd2);
  endfunction

  state_t          state_r;
  logic [XW-1:0]   x_r;
  logic [YW-1:0]   y_r;
  logic            pipe_valid_r;
  logic [7:0]      pipe_luma_r;
  logic [KW-1:0]   pipe_key_r;
  logic            pipe_band_r;
  logic [11:0]     cnt_r    [KEYS];
  logic [1:0]      streak_r [KEYS];
  logic [KEYS-1:0] next_state_r;
  logic [KW-1:0]   eval_idx_r;
  logic [7:0]      drop_cnt_r;

  logic            first_s;
  logic            accum_s;
  logic            restart_s;
  logic            last_s;
  logic            take_s;
  logic [XW-1:0]   pos_x_s;
  logic [YW-1:0]   pos_y_s;
  logic [KW-1:0]   pos_key_s;
  logic            pos_band_s;
  logic            dark_s;
  logic [11:0]     eval_cnt_s;
  logic            eval_ns_s;
  logic [1:0]      eval_streak_s;
  logic [1:0]      streak_inc_s;
  logic            vote_s;

  // Pixel acceptance, frame-position decode and per-key evaluation votes.
  always_comb begin
    first_s       = 1'b0;
    accum_s       = 1'b0;
    pos_x_s       = x_r;
    pos_y_s       = y_r;
    if (state_r == WAIT_SOF) begin
      first_s = pix_valid & pix_sof;
    end else begin
      first_s = 1'b0;
    end
    if (state_r == ACCUM) begin
      accum_s = pix_valid;
    end else begin
      accum_s = 1'b0;
    end
    restart_s = accum_s & pix_sof & ~((x_r == {XW{1'b0}}) & (y_r == {YW{1'b0}}));
    last_s    = accum_s & ~restart_s & (x_r == X_LAST) & (y_r == Y_LAST);
    take_s    = first_s | accum_s;
    // A sof pixel always lands at the frame origin, whatever the current position.
    if (first_s | restart_s) begin
      pos_x_s = {XW{1'b0}};
      pos_y_s = {YW{1'b0}};
    end else begin
      pos_x_s = x_r;
      pos_y_s = y_r;
    end
    pos_key_s     = KW'(pos_x_s / X_KEYW);
    pos_band_s    = (pos_y_s >= Y_TOP) && (pos_y_s <= Y_BOT);
    dark_s        = pipe_valid_r & pipe_band_r & (pipe_luma_r < LUMA_TH);
    eval_cnt_s    = cnt_r[eval_idx_r];
    eval_ns_s     = next_state_r[eval_idx_r];
    eval_streak_s = streak_r[eval_idx_r];
    streak_inc_s  = eval_streak_s + 2'd1;
    if (eval_ns_s) begin
      vote_s = (eval_cnt_s < OFF_TH);
    end else begin
      vote_s = (eval_cnt_s > ON_TH);
    end
  end

  // Frame FSM with luma pipeline, column counters, debounce state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= WAIT_SOF;
      x_r          <= {XW{1'b0}};
      y_r          <= {YW{1'b0}};
      pipe_valid_r <= 1'b0;
      pipe_luma_r  <= 8'd0;
      pipe_key_r   <= {KW{1'b0}};
      pipe_band_r  <= 1'b0;
      next_state_r <= {KEYS{1'b0}};
      eval_idx_r   <= {KW{1'b0}};
      drop_cnt_r   <= 8'd0;
      key_state    <= {KEYS{1'b0}};
      key_on       <= {KEYS{1'b0}};
      key_off      <= {KEYS{1'b0}};
      frame_done   <= 1'b0;
      for (int i = 0; i < KEYS; i++) begin
        cnt_r[i]    <= 12'd0;
        streak_r[i] <= 2'd0;
      end
    end else begin
      frame_done   <= 1'b0;
      key_on       <= {KEYS{1'b0}};
      key_off      <= {KEYS{1'b0}};
      pipe_valid_r <= take_s;
      if (take_s) begin
        pipe_luma_r <= luma_f(pix_data);
        pipe_key_r  <= pos_key_s;
        pipe_band_r <= pos_band_s;
      end
      // On restart the in-flight pixel belongs to the aborted frame, so the clear wins.
      if (restart_s) begin
        for (int i = 0; i < KEYS; i++) begin
          cnt_r[i] <= 12'd0;
        end
      end else if (dark_s) begin
        cnt_r[pipe_key_r] <= cnt_r[pipe_key_r] + 12'd1;
      end
      case (state_r)
        WAIT_SOF: begin
          if (first_s) begin
            x_r     <= XW'(1);
            y_r     <= {YW{1'b0}};
            state_r <= ACCUM;
          end
        end
        ACCUM: begin
          if (restart_s) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
            x_r        <= XW'(1);
            y_r        <= {YW{1'b0}};
          end else if (last_s) begin
            state_r <= FLUSH;
          end else if (accum_s) begin
            if (x_r == X_LAST) begin
              x_r <= {XW{1'b0}};
              y_r <= y_r + YW'(1);
            end else begin
              x_r <= x_r + XW'(1);
            end
          end
        end
        FLUSH: begin
          eval_idx_r <= {KW{1'b0}};
          state_r    <= EVAL;
        end
        EVAL: begin
          if (vote_s) begin
            if (streak_inc_s == DEB) begin
              next_state_r[eval_idx_r] <= ~eval_ns_s;
              streak_r[eval_idx_r]     <= 2'd0;
            end else begin
              streak_r[eval_idx_r] <= streak_inc_s;
            end
          end else begin
            streak_r[eval_idx_r] <= 2'd0;
          end
          if (eval_idx_r == K_LAST) begin
            state_r <= PUBLISH;
          end else begin
            eval_idx_r <= eval_idx_r + KW'(1);
          end
        end
        PUBLISH: begin
          key_state  <= next_state_r;
          key_on     <= next_state_r & ~key_state;
          key_off    <= ~next_state_r & key_state;
          frame_done <= 1'b1;
          for (int i = 0; i < KEYS; i++) begin
            cnt_r[i] <= 12'd0;
          end
          state_r <= WAIT_SOF;
        end
        default: begin
          state_r <= WAIT_SOF;
        end
      endcase
    end
  end

  assign debug_out = {drop_cnt_r, key_state[7:0]};

endmodule

// File: tb/tb_key_detector.sv
// Scoreboard bench for key_detector on a reduced 32x24 image: a frame-level reference
// model predicts each published result and a negedge monitor checks the DUT outputs.
module tb_key_detector;

  localparam int          W   = 32;
  localparam int          H   = 24;
  localparam int          K   = 8;
  localparam int          KWD = W / K;
  localparam int          RT  = 16;
  localparam int          RB  = 23;
  localparam logic [11:0] ON  = 12'd20;
  localparam logic [11:0] OFF = 12'd12;
  localparam int          DEB = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic        pix_sof;
  logic [15:0] pix_data;
  logic [7:0]  key_state;
  logic [7:0]  key_on;
  logic [7:0]  key_off;
  logic        frame_done;
  logic [15:0] debug_out;

  always #5 clk = ~clk;

  key_detector #(
    .IMG_W(W), .IMG_H(H), .KEYS(K), .ROW_TOP(RT), .ROW_BOT(RB),
    .LUMA_TH(8'd60), .ON_TH(ON), .OFF_TH(OFF), .DEBOUNCE(DEB)
  ) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
    .key_state(key_state), .key_on(key_on), .key_off(key_off),
    .frame_done(frame_done), .debug_out(debug_out)
  );

  typedef struct {
    logic [7:0] st;
    logic [7:0] on;
    logic [7:0] off;
    int         cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [15:0] fr [H][W];
  logic [7:0]  m_state;
  int          m_streak [K];
  logic [7:0]  pub_state = 8'd0;
  logic [7:0]  drop_exp = 8'd0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int luma(input logic [15:0] p);
    return 2 * int'(p[15:11]) + 2 * int'(p[10:5]) + 2 * int'(p[4:0]);
  endfunction

  task automatic model_reset();
    m_state = 8'd0;
    for (int k = 0; k < K; k++) m_streak[k] = 0;
  endtask

  // Count dark band pixels per column, apply hysteresis/debounce, queue expected result.
  task automatic model_frame(input int c0);
    int         cnt [K];
    exp_t       e;
    logic [7:0] old_s;
    bit         vote;
    for (int k = 0; k < K; k++) cnt[k] = 0;
    for (int y = RT; y <= RB; y++)
      for (int x = 0; x < W; x++)
        if (luma(fr[y][x]) < 60) cnt[x / KWD]++;
    old_s = m_state;
    for (int k = 0; k < K; k++) begin
      if (m_state[k]) vote = (cnt[k] < int'(OFF));
      else            vote = (cnt[k] > int'(ON));
      if (vote) begin
        m_streak[k]++;
        if (m_streak[k] == DEB) begin
          m_state[k]  = ~m_state[k];
          m_streak[k] = 0;
        end
      end else begin
        m_streak[k] = 0;
      end
    end
    e.st  = m_state;
    e.on  = m_state & ~old_s;
    e.off = old_s & ~m_state;
    e.cyc = c0 + 10;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic s, input logic [15:0] d);
    pix_valid = v;
    pix_sof   = s;
    pix_data  = d;
    @(posedge clk);
    #1;
  endtask

  // Idle cycles carry random junk pixels without sof; the DUT must discard them.
  task automatic idle(input int n);
    repeat (n) drive(1'($urandom_range(1, 0)), 1'b0, 16'($urandom));
  endtask

  task automatic send_frame(input int gap_pct, input bit with_sof, input bit expect_out,
                            input bit is_restart);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        while (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct)
          drive(1'b0, 1'b0, 16'($urandom));
        drive(1'b1, with_sof && x == 0 && y == 0, fr[y][x]);
        if (is_restart && x == 0 && y == 0) drop_exp = drop_exp + 8'd1;
      end
    if (expect_out) model_frame(cyc);
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, i == 0, fr[i / W][i % W]);
  endtask

  task automatic fill_white();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) fr[y][x] = 16'hFFFF;
  endtask

  task automatic fill_key_black(input int k);
    fill_white();
    for (int y = RT; y <= RB; y++)
      for (int x = k * KWD; x < (k + 1) * KWD; x++) fr[y][x] = 16'h0000;
  endtask

  // Key 0 gets n dark band pixels, always including the band/column corner pixel;
  // extras darken the row just above the band and the first column of key 1.
  task automatic fill_key0(input int n, input bit extras);
    int left;
    fill_white();
    fr[RT][KWD-1] = 16'h0000;
    left = n - 1;
    for (int y = RT; y <= RB; y++)
      for (int x = 0; x < KWD; x++)
        if (left > 0 && !(y == RT && x == KWD - 1)) begin
          fr[y][x] = 16'h0000;
          left--;
        end
    if (extras) begin
      for (int x = 0; x < KWD; x++) fr[RT-1][x] = 16'h0000;
      for (int y = RT; y <= RB; y++) fr[y][KWD] = 16'h0000;
    end
  endtask

  task automatic fill_random();
    int pct [K];
    for (int k = 0; k < K; k++) pct[k] = 25 * int'($urandom_range(4, 0));
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (y >= RT && y <= RB) begin
          if (int'($urandom_range(99, 0)) < pct[x / KWD]) fr[y][x] = 16'($urandom) & 16'h18E3;
          else fr[y][x] = 16'($urandom) | 16'h8410;
        end else begin
          fr[y][x] = 16'($urandom);
        end
  endtask

  // Monitor: pop and compare on every frame_done; otherwise outputs must hold steady.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      pub_state = 8'd0;
    end else if (mon_en) begin
      if (frame_done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_frame_done", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("frame_result", {key_state, key_on, key_off, 32'(cyc)},
                {e.st, e.on, e.off, 32'(e.cyc)});
          pub_state = e.st;
        end
      end else begin
        check("between_frames", {key_state, key_on, key_off}, {pub_state, 8'd0, 8'd0});
      end
      check("debug_out", debug_out, {drop_exp, pub_state});
    end
  end

  initial begin
    rst       = 1'b0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = 16'h0000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {key_state, key_on, key_off, frame_done, debug_out}, 64'd0);
    rst    = 1'b1;
    mon_en = 1'b1;
    idle(4);

    fill_white();
    repeat (3) begin send_frame(0, 1'b1, 1'b1, 1'b0); idle(14); end

    fill_key_black(3);
    repeat (2) begin send_frame(5, 1'b1, 1'b1, 1'b0); idle(14); end
    check("key3_pressed", key_state, 8'h08);
    fill_white();
    repeat (2) begin send_frame(0, 1'b1, 1'b1, 1'b0); idle(14); end
    check("key3_released", key_state, 8'h00);

    fill_key0(16, 1'b0);
    repeat (4) begin send_frame(0, 1'b1, 1'b1, 1'b0); idle(14); end
    check("key0_hold_between_th", key_state, 8'h00);
    fill_key0(int'(ON) + 1, 1'b0);
    repeat (2) begin send_frame(0, 1'b1, 1'b1, 1'b0); idle(14); end
    check("key0_corner_counts", key_state, 8'h01);
    fill_key0(int'(OFF) - 1, 1'b1);
    repeat (2) begin send_frame(0, 1'b1, 1'b1, 1'b0); idle(14); end
    check("key0_outside_ignored", key_state, 8'h00);

    fill_white();
    send_partial(W * 10 + 3);
    fill_key_black(3);
    send_frame(0, 1'b1, 1'b1, 1'b1);
    idle(14);
    check("drop_after_restart", debug_out[15:8], 8'd1);
    send_partial(W * H - 1);
    send_frame(0, 1'b1, 1'b1, 1'b1);
    idle(14);
    check("drop_last_pixel_sof", debug_out[15:8], 8'd2);
    check("pre_reset_state", key_state, 8'h08);

    send_partial(W * 5);
    rst = 1'b0;
    #1;
    check("reset_mid_accum", {key_state, key_on, key_off, frame_done, debug_out}, 64'd0);
    sb_q.delete();
    model_reset();
    drop_exp = 8'd0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    fill_key_black(3);
    send_frame(0, 1'b0, 1'b0, 1'b0);
    idle(20);
    check("no_sof_ignored", key_state, 8'h00);

    for (int f = 0; f < 20; f++) begin
      bit rs;
      rs = ($urandom_range(9, 0) == 0);
      if (rs) begin fill_random(); send_partial(int'($urandom_range(W * H - 1, 1))); end
      fill_random();
      send_frame(int'($urandom_range(20, 0)), 1'b1, 1'b1, rs);
      idle(14);
    end

    for (int i = 0; i < 50 && sb_q.size() > 0; i++) @(posedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
